// File: rtl/uart_rx_fifo_if.sv
// Avalon-MM slave register bus of the UART receiver.
// The slave modport is the receiver side; the master modport is the host side.
interface uart_rx_fifo_if;
   logic [3:0] avms_address_i;
   logic       avms_read_i;
   logic       avms_write_i;
   logic [7:0] avms_writedata_i;
   logic [7:0] avms_readdata_o;

   modport slave (
      input  avms_address_i,
      input  avms_read_i,
      input  avms_write_i,
      input  avms_writedata_i,
      output avms_readdata_o
   );

   modport master (
      output avms_address_i,
      output avms_read_i,
      output avms_write_i,
      output avms_writedata_i,
      input  avms_readdata_o
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a receive FIFO.
// The FIFO and its status, error and interrupt registers are read and written over an Avalon-MM slave bus.
//
// state     | meaning
// IDLE      | line idle, waiting for a falling edge
// START     | half-bit delay, then re-check that the start bit is still low
// DATA      | sample 8 data bits, LSB first, one per bit period
// STOP      | sample the stop bit; push the byte or flag a framing error
// WAIT_HIGH | after a framing error, wait for the line to return high
module uart_rx_fifo #(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic            clk_i,
   input  logic            arst_n_i,
   uart_rx_fifo_if.slave   avms,
   input  logic            uart_rxd_i,
   output logic            IRQ_event
);

   localparam int DIV = CLK_FREQ / BAUD_RATE;
   localparam int BW  = $clog2(DIV + 1);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = AW + 1;
   localparam logic [BW-1:0] LOAD_HALF = BW'(DIV / 2 - 1);
   localparam logic [BW-1:0] LOAD_FULL = BW'(DIV - 1);
   localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

   state_t          state, state_n;
   logic [1:0]      rxd_sync;
   logic            rxd_s, rxd_prev;
   logic [BW-1:0]   baud_cnt;
   logic            baud_tc;
   logic [2:0]      bit_cnt;
   logic [7:0]      shift_q;
   logic            load_half, load_full, shift_en, push_req, ferr_set;

   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count;
   logic            not_empty, full, pop, push_ok, ovr_set;
   logic            ovr, ferr;
   logic [1:0]      irq_en;
   logic            wr_status, wr_irq_en;
   logic [7:0]      status;
   logic            unused_wdata;

   assign unused_wdata = ^{avms.avms_writedata_i[7:4]};

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         rxd_sync <= 2'b11;
         rxd_prev <= 1'b1;
      end else begin
         rxd_sync <= {rxd_sync[0], uart_rxd_i};
         rxd_prev <= rxd_sync[1];
      end
   end
   assign rxd_s = rxd_sync[1];

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) state <= IDLE;
      else           state <= state_n;
   end

   always_comb begin
      state_n   = state;
      load_half = 1'b0;
      load_full = 1'b0;
      shift_en  = 1'b0;
      push_req  = 1'b0;
      ferr_set  = 1'b0;
      case (state)
         IDLE: begin
            if (rxd_prev && !rxd_s) begin
               state_n   = START;
               load_half = 1'b1;
            end
         end
         START: begin
            if (baud_tc) begin
               if (!rxd_s) begin
                  state_n   = DATA;
                  load_full = 1'b1;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         DATA: begin
            if (baud_tc) begin
               shift_en  = 1'b1;
               load_full = 1'b1;
               if (bit_cnt == 3'd7) state_n = STOP;
            end
         end
         STOP: begin
            if (baud_tc) begin
               if (rxd_s) begin
                  push_req = 1'b1;
                  state_n  = IDLE;
               end else begin
                  ferr_set = 1'b1;
                  state_n  = WAIT_HIGH;
               end
            end
         end
         WAIT_HIGH: begin
            if (rxd_s) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign baud_tc = (baud_cnt == '0);

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shift_q  <= '0;
      end else begin
         if (load_half)      baud_cnt <= LOAD_HALF;
         else if (load_full) baud_cnt <= LOAD_FULL;
         else if (!baud_tc)  baud_cnt <= baud_cnt - BW'(1);

         if (load_half)     bit_cnt <= '0;
         else if (shift_en) bit_cnt <= bit_cnt + 3'd1;

         if (shift_en) shift_q <= {rxd_s, shift_q[7:1]};
      end
   end

   assign not_empty = (count != '0);
   assign full      = (count == DEPTH_C);
   assign pop       = avms.avms_read_i && (avms.avms_address_i == 4'h0) && not_empty;
   // A pop in the same cycle frees a slot, so a push at full still lands.
   assign push_ok   = push_req && (!full || pop);
   assign ovr_set   = push_req && full && !pop;
   assign wr_status = avms.avms_write_i && (avms.avms_address_i == 4'h1);
   assign wr_irq_en = avms.avms_write_i && (avms.avms_address_i == 4'h2);
   assign status    = {4'b0000, ferr, ovr, full, not_empty};

   always_ff @(posedge clk_i) begin
      if (push_ok) mem[wr_ptr] <= shift_q;
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Set has priority over a same-cycle write-1-to-clear.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         ovr    <= 1'b0;
         ferr   <= 1'b0;
         irq_en <= 2'b00;
      end else begin
         if (ovr_set)                                 ovr  <= 1'b1;
         else if (wr_status && avms.avms_writedata_i[2]) ovr  <= 1'b0;
         if (ferr_set)                                ferr <= 1'b1;
         else if (wr_status && avms.avms_writedata_i[3]) ferr <= 1'b0;
         if (wr_irq_en) irq_en <= avms.avms_writedata_i[1:0];
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         avms.avms_readdata_o <= 8'h00;
      end else if (avms.avms_read_i) begin
         case (avms.avms_address_i)
            4'h0:    avms.avms_readdata_o <= not_empty ? mem[rd_ptr] : 8'h00;
            4'h1:    avms.avms_readdata_o <= status;
            4'h2:    avms.avms_readdata_o <= {6'b000000, irq_en};
            4'h3:    avms.avms_readdata_o <= 8'(count);
            default: avms.avms_readdata_o <= 8'h00;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) IRQ_event <= 1'b0;
      else           IRQ_event <= (irq_en[0] && not_empty) || (irq_en[1] && (ovr || ferr));
   end

endmodule
